// File: rtl/cv32e40s_pkg.sv
// Shared types for the fetch path: one buffered fetch word with its address and bus-error flag.
package cv32e40s_pkg;

   localparam logic [31:0] FETCH_STRIDE = 32'd4;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        err;
   } fetch_word_t;

endpackage

// File: rtl/cv32e40s_fetch_fifo.sv
// Synchronous FIFO of fetch words with same-cycle flush; flush wins over push and pop.
module cv32e40s_fetch_fifo
   import cv32e40s_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  fetch_word_t      push_data_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] count_o,
   output logic             valid_o,
   output fetch_word_t      head_o
);

   // Storage is rounded up to a power of two so the pointers wrap naturally;
   // occupancy is still bounded by DEPTH through the upstream credit check.
   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_word_t      mem_q [2**PTR_W];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_en, pop_en;

   assign pop_en  = pop_i & (cnt_q != '0) & ~flush_i;
   assign push_en = push_i & ~flush_i & ((cnt_q != CNT_W'(DEPTH)) | pop_en);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = cnt_q;
   assign valid_o = (cnt_q != '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cv32e40s_fetch_queue.sv
// Sequential word fetcher with credit-limited issue, branch kill with response discard,
// error stop and external halt; responses are buffered in order for the consumer.
module cv32e40s_fetch_queue
   import cv32e40s_pkg::*;
#(
   parameter int unsigned DEPTH       = 3,
   parameter int unsigned MAX_OUTSTND = 2,
   parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch_i,
   input  logic [31:0]      branch_addr_i,
   input  logic             halt_i,
   output logic             trans_valid_o,
   input  logic             trans_ready_i,
   output logic [31:0]      trans_addr_o,
   input  logic             resp_valid_i,
   input  logic [31:0]      resp_rdata_i,
   input  logic             resp_err_i,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic [31:0]      word_rdata_o,
   output logic [31:0]      word_addr_o,
   output logic             word_err_o,
   output logic [CNT_W-1:0] outstnd_cnt_o,
   output logic             busy_o
);

   localparam int unsigned AQ_W = (MAX_OUTSTND > 1) ? $clog2(MAX_OUTSTND) : 1;

   // Handshake rule for both request and word ports: a transfer happens in a cycle where
   // valid & ready are both high; once raised, trans_valid_o and its address stay put until
   // accepted (only a branch may retarget the address).

   logic             active_q, active_d;
   logic             err_stop_q, err_stop_d;
   logic             hold_q, hold_d;
   logic [31:0]      next_addr_q, next_addr_d;
   logic [CNT_W-1:0] outstnd_q, outstnd_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [31:0]      aq_q [2**AQ_W];
   logic [AQ_W-1:0]  aq_rd_q, aq_rd_d;
   logic [AQ_W-1:0]  aq_wr_q, aq_wr_d;
   logic [AQ_W-1:0]  aq_wr_sel;

   logic [31:0]      branch_tgt;
   logic [CNT_W:0]   credit_sum;
   logic             credit_ok, issue_ok, trans_hs;
   logic             resp_ok, resp_take, resp_keep;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_valid;
   fetch_word_t      fifo_head, push_word;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^branch_addr_i[1:0];
   assign branch_tgt       = {branch_addr_i[31:2], 2'b00};

   assign credit_sum = {1'b0, outstnd_q} + {1'b0, fifo_cnt};
   assign credit_ok  = (outstnd_q < CNT_W'(MAX_OUTSTND)) && (credit_sum < (CNT_W+1)'(DEPTH));
   // A branch starts from an empty pipe, so credit is implicitly available in that cycle.
   assign issue_ok   = ~halt_i & (branch_i | (active_q & ~err_stop_q & credit_ok));

   assign trans_valid_o = ~rst & (hold_q | issue_ok);
   assign trans_addr_o  = branch_i ? branch_tgt : next_addr_q;
   assign trans_hs      = trans_valid_o & trans_ready_i;

   // Responses with nothing in flight (e.g. stragglers after a reset) are ignored entirely.
   assign resp_ok   = resp_valid_i & ((outstnd_q != '0) | (discard_q != '0));
   assign resp_take = resp_ok & (discard_q == '0);
   assign resp_keep = resp_take & ~branch_i;

   assign aq_wr_sel = branch_i ? '0 : aq_wr_q;

   always_comb begin
      active_d    = active_q | branch_i;
      err_stop_d  = err_stop_q;
      hold_d      = trans_valid_o & ~trans_ready_i;
      next_addr_d = trans_hs ? trans_addr_o + FETCH_STRIDE : trans_addr_o;
      outstnd_d   = outstnd_q;
      discard_d   = discard_q;
      aq_rd_d     = aq_rd_q;
      aq_wr_d     = aq_wr_q;
      if (branch_i) begin
         err_stop_d = 1'b0;
         outstnd_d  = trans_hs ? CNT_W'(1) : '0;
         discard_d  = outstnd_q + discard_q - (resp_ok ? CNT_W'(1) : '0);
         aq_rd_d    = '0;
         aq_wr_d    = trans_hs ? AQ_W'(1) : '0;
      end else begin
         if (resp_keep & resp_err_i) err_stop_d = 1'b1;
         case ({trans_hs, resp_take})
            2'b10:   outstnd_d = outstnd_q + CNT_W'(1);
            2'b01:   outstnd_d = outstnd_q - CNT_W'(1);
            default: outstnd_d = outstnd_q;
         endcase
         if (resp_ok & (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
         if (trans_hs)  aq_wr_d = aq_wr_q + AQ_W'(1);
         if (resp_keep) aq_rd_d = aq_rd_q + AQ_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q    <= 1'b0;
         err_stop_q  <= 1'b0;
         hold_q      <= 1'b0;
         next_addr_q <= '0;
         outstnd_q   <= '0;
         discard_q   <= '0;
         aq_rd_q     <= '0;
         aq_wr_q     <= '0;
      end else begin
         active_q    <= active_d;
         err_stop_q  <= err_stop_d;
         hold_q      <= hold_d;
         next_addr_q <= next_addr_d;
         outstnd_q   <= outstnd_d;
         discard_q   <= discard_d;
         aq_rd_q     <= aq_rd_d;
         aq_wr_q     <= aq_wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (trans_hs) aq_q[aq_wr_sel] <= trans_addr_o;
   end

   assign push_word.rdata = resp_rdata_i;
   assign push_word.addr  = aq_q[aq_rd_q];
   assign push_word.err   = resp_err_i;

   cv32e40s_fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (branch_i),
      .push_i      (resp_keep),
      .push_data_i (push_word),
      .pop_i       (word_valid_o & word_ready_i),
      .count_o     (fifo_cnt),
      .valid_o     (fifo_valid),
      .head_o      (fifo_head)
   );

   assign word_valid_o  = ~rst & fifo_valid;
   assign word_rdata_o  = word_valid_o ? fifo_head.rdata : '0;
   assign word_addr_o   = word_valid_o ? fifo_head.addr  : '0;
   assign word_err_o    = word_valid_o & fifo_head.err;
   assign outstnd_cnt_o = rst ? '0 : outstnd_q;
   assign busy_o        = ~rst & ((outstnd_q != '0) | (discard_q != '0));

endmodule

// File: tb/tb_cv32e40s_fetch_queue.sv
// Bench for cv32e40s_fetch_queue: in-order bus responder, word scoreboard, vector table and corner sequences.
module tb_cv32e40s_fetch_queue;

   localparam int DEPTH       = 3;
   localparam int MAX_OUTSTND = 2;
   localparam int CNT_W       = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             branch_i;
   logic [31:0]      branch_addr_i;
   logic             halt_i;
   logic             trans_valid_o;
   logic             trans_ready_i;
   logic [31:0]      trans_addr_o;
   logic             resp_valid_i;
   logic [31:0]      resp_rdata_i;
   logic             resp_err_i;
   logic             word_valid_o;
   logic             word_ready_i;
   logic [31:0]      word_rdata_o;
   logic [31:0]      word_addr_o;
   logic             word_err_o;
   logic [CNT_W-1:0] outstnd_cnt_o;
   logic             busy_o;

   cv32e40s_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTND(MAX_OUTSTND)) dut (
      .clk(clk), .rst(rst), .branch_i(branch_i), .branch_addr_i(branch_addr_i), .halt_i(halt_i),
      .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o),
      .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
      .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .word_rdata_o(word_rdata_o),
      .word_addr_o(word_addr_o), .word_err_o(word_err_o), .outstnd_cnt_o(outstnd_cnt_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        err;
      logic        killed;
      logic        ghost;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] target;
      int          lat;
      int          words;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   req_t        pend_q[$];
   logic [64:0] exp_q[$];
   vec_t        tbl[5];

   int          cyc = 0, n_vec = 0, n_fail = 0;
   logic        rst_v = 1'b1, br = 1'b0, halt = 1'b0, tready = 1'b0, wready = 1'b0, err_rand = 1'b0;
   logic [31:0] br_addr = '0, err_addr = 32'h1, m_next = '0;
   int          lat = 1;
   int          hs_cnt, pop_cnt, want_pops, tv_cnt, t_resp, t_wv;
   logic [31:0] first_hs_addr, first_pop_addr, nth_pop_addr, err_pop_addr, ta_s;
   logic        tv_s, wv_s;
   logic [64:0] wd_s;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int live_cnt();
      int n = 0;
      foreach (pend_q[i]) if (!pend_q[i].killed && !pend_q[i].ghost) n++;
      return n;
   endfunction

   function automatic logic busy_m();
      logic b = 1'b0;
      foreach (pend_q[i]) if (!pend_q[i].ghost) b = 1'b1;
      return b;
   endfunction

   task automatic clear_marks();
      hs_cnt = 0; pop_cnt = 0; tv_cnt = 0; t_resp = -1; t_wv = -1;
      first_hs_addr = '0; first_pop_addr = '0; nth_pop_addr = '0; err_pop_addr = '0;
   endtask

   task automatic start_reset();
      rst_v = 1'b1;
      foreach (pend_q[i]) pend_q[i].ghost = 1'b1;
      exp_q.delete();
   endtask

   // One clock: drive at the falling edge, sample 1 time unit later, update the model before the rising edge.
   task automatic cycle();
      req_t r;
      @(negedge clk);
      rst = rst_v; branch_i = br; branch_addr_i = br_addr; halt_i = halt;
      trans_ready_i = tready; word_ready_i = wready;
      resp_valid_i = 1'b0; resp_rdata_i = '0; resp_err_i = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         resp_valid_i = 1'b1; resp_rdata_i = pend_q[0].rdata; resp_err_i = pend_q[0].err;
      end
      #1;
      tv_s = trans_valid_o; ta_s = trans_addr_o; wv_s = word_valid_o;
      wd_s = {word_rdata_o, word_addr_o, word_err_o};
      if (tv_s) tv_cnt++;
      chk("word_valid", word_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("word_head", wd_s, exp_q[0]);
      chk("outstnd_cnt", outstnd_cnt_o, live_cnt());
      chk("busy", busy_o, busy_m());
      if (!rst_v) begin
         if (word_valid_o && word_ready_i && exp_q.size() != 0) begin
            r.addr = exp_q[0][32:1];
            void'(exp_q.pop_front());
            if (!br) begin
               if (pop_cnt == 0) first_pop_addr = word_addr_o;
               pop_cnt++;
               if (pop_cnt == want_pops) nth_pop_addr = word_addr_o;
               if (word_err_o) err_pop_addr = word_addr_o;
            end
         end
         if (br) begin
            foreach (pend_q[i]) pend_q[i].killed = 1'b1;
            exp_q.delete();
            m_next = {br_addr[31:2], 2'b00};
         end
         if (word_valid_o && !br && t_wv < 0) t_wv = cyc;
      end
      if (resp_valid_i) begin
         r = pend_q.pop_front();
         if (!rst_v && !r.killed && !r.ghost && !br) exp_q.push_back({r.rdata, r.addr, r.err});
         if (!r.ghost && t_resp < 0) t_resp = cyc;
      end
      if (!rst_v && trans_valid_o && trans_ready_i) begin
         chk("req_addr", trans_addr_o, m_next);
         if (hs_cnt == 0) first_hs_addr = trans_addr_o;
         hs_cnt++;
         r.addr = m_next; r.rdata = $urandom; r.killed = 1'b0; r.ghost = 1'b0; r.due = cyc + lat;
         r.err = (m_next == err_addr) || (err_rand && $urandom_range(0, 15) == 0);
         pend_q.push_back(r);
         m_next = m_next + 32'd4;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      tbl[0] = '{32'h0000_0100, 1, 3, 32'h0000_0100, 32'h0000_0108};
      tbl[1] = '{32'hFFFF_FFFE, 1, 2, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[2] = '{32'h0000_1003, 3, 4, 32'h0000_1000, 32'h0000_100C};
      tbl[3] = '{32'h2000_0001, 2, 5, 32'h2000_0000, 32'h2000_0010};
      tbl[4] = '{32'h7FFF_FFF8, 1, 4, 32'h7FFF_FFF8, 32'h8000_0004};
      want_pops = 0;
      clear_marks();

      // reset state and idle without a branch
      rst = 1'b1; branch_i = 0; branch_addr_i = 0; halt_i = 0; trans_ready_i = 0;
      word_ready_i = 0; resp_valid_i = 0; resp_rdata_i = 0; resp_err_i = 0;
      run(3);
      chk("rst_trans_valid", tv_s, 1'b0);
      chk("rst_word_fields", wd_s, '0);
      rst_v = 1'b0; tready = 1'b1; wready = 1'b1;
      clear_marks();
      run(6);
      chk("idle_no_fetch", tv_cnt, 0);

      // first-word latency: request at N, response at N+1, word visible at N+2
      lat = 1; br = 1'b1; br_addr = 32'h100; clear_marks(); want_pops = 3;
      begin
         int br_cyc;
         br_cyc = cyc;
         cycle(); br = 1'b0;
         run(6);
         chk("lat_first_resp", t_resp, br_cyc + 1);
         chk("lat_first_word", t_wv, br_cyc + 2);
         chk("lat_first_addr", first_pop_addr, 32'h100);
      end

      // vector table: branch target, latency, words to collect, expected first/last addresses
      for (int v = 0; v < 5; v++) begin
         lat = tbl[v].lat; br = 1'b1; br_addr = tbl[v].target; tready = 1'b1; wready = 1'b1;
         clear_marks(); want_pops = tbl[v].words;
         cycle(); br = 1'b0;
         for (int i = 0; i < 200 && pop_cnt < want_pops; i++) cycle();
         chk("tbl_pops", pop_cnt, tbl[v].words);
         chk("tbl_first_req", first_hs_addr, tbl[v].exp_first);
         chk("tbl_first_word", first_pop_addr, tbl[v].exp_first);
         chk("tbl_last_word", nth_pop_addr, tbl[v].exp_last);
      end

      // backpressure: consumer stalled, issue stops at DEPTH credits
      lat = 1; wready = 1'b0; br = 1'b1; br_addr = 32'h300; clear_marks();
      cycle(); br = 1'b0;
      run(11);
      chk("bp_reqs", hs_cnt, 3);
      chk("bp_stalled", tv_s, 1'b0);
      wready = 1'b1; cycle();
      chk("bp_pop_cycle_no_issue", tv_s, 1'b0);
      wready = 1'b0; cycle();
      chk("bp_credit_next_cycle", tv_s, 1'b1);
      run(6);
      chk("bp_reqs_after_pop", hs_cnt, 4);
      wready = 1'b1; run(8);

      // branch kill with two responses still in flight
      lat = 3; br = 1'b1; br_addr = 32'h400; clear_marks();
      cycle(); br = 1'b0;
      for (int i = 0; i < 20 && live_cnt() != 2; i++) cycle();
      chk("kill_inflight", live_cnt(), 2);
      br = 1'b1; br_addr = 32'h200; clear_marks(); want_pops = 1;
      cycle(); br = 1'b0;
      cycle();
      chk("kill_flushed", wv_s, 1'b0);
      for (int i = 0; i < 40 && pop_cnt < 1; i++) cycle();
      chk("kill_first_word", first_pop_addr, 32'h200);

      // bus error on 0x104 stops issue until the next branch
      lat = 1; err_addr = 32'h104; br = 1'b1; br_addr = 32'h100; clear_marks();
      cycle(); br = 1'b0;
      run(10);
      chk("err_reqs", hs_cnt, 3);
      chk("err_word_addr", err_pop_addr, 32'h104);
      chk("err_stopped", tv_s, 1'b0);
      err_addr = 32'h1; br = 1'b1; br_addr = 32'h600; clear_marks();
      cycle(); br = 1'b0;
      run(4);
      chk("err_resume_addr", first_hs_addr, 32'h600);

      // halt while a request is waiting for ready
      tready = 1'b0; br = 1'b1; br_addr = 32'h700; clear_marks();
      cycle(); br = 1'b0; halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("halt_hold_valid", tv_s, 1'b1);
         chk("halt_hold_addr", ta_s, 32'h700);
      end
      tready = 1'b1; cycle();
      chk("halt_accepted", hs_cnt, 1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("halt_no_issue", tv_s, 1'b0);
      end
      halt = 1'b0; cycle();
      chk("halt_release_valid", tv_s, 1'b1);
      chk("halt_release_addr", ta_s, 32'h704);
      run(6);

      // reset mid-operation: late responses must not be counted
      lat = 3; br = 1'b1; br_addr = 32'h800; clear_marks();
      cycle(); br = 1'b0;
      for (int i = 0; i < 20 && live_cnt() != 2; i++) cycle();
      start_reset(); cycle();
      rst_v = 1'b0; clear_marks(); run(8);
      chk("rst_mid_no_fetch", tv_cnt, 0);
      chk("rst_mid_drained", pend_q.size(), 0);
      lat = 1; br = 1'b1; br_addr = 32'h900; clear_marks(); want_pops = 1;
      cycle(); br = 1'b0;
      for (int i = 0; i < 20 && pop_cnt < 1; i++) cycle();
      chk("rst_mid_restart", first_pop_addr, 32'h900);

      // random traffic, branches, halts and errors
      err_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         tready = ($urandom_range(0, 3) != 0);
         wready = ($urandom_range(0, 2) != 0);
         halt   = ($urandom_range(0, 9) == 0);
         lat    = $urandom_range(1, 4);
         br     = ($urandom_range(0, 24) == 0);
         br_addr = $urandom;
         cycle();
      end
      br = 1'b0; halt = 1'b0; err_rand = 1'b0; tready = 1'b1; wready = 1'b1; lat = 1;
      run(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
